// File: rtl/spi_rx_collector.sv
// SPI mode-0 read engine feeding a FIFO; stalls SCLK between bytes on full.
// Define SPI_LSB_FIRST_EN to assemble bytes LSB first (default MSB first).
module spi_rx_collector #(
  parameter int CLK_DIV   = 4,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] rd_len,
  output logic                 busy,
  output logic                 done,
  output logic                 spi_sclk,
  output logic                 spi_cs_n,
  input  logic                 spi_miso,
  output logic [7:0]           fifo_din,
  output logic                 fifo_wr_en,
  input  logic                 fifo_full
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    PUSH,
    HOLD,
    FINISH
  } state_e;

  state_e               state_q;
  logic [DW-1:0]        div_q;
  logic [2:0]           bit_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [7:0]           shift_q;
  logic [7:0]           shift_d;
  logic                 busy_q;
  logic                 done_q;
  logic                 sclk_q;
  logic                 cs_n_q;
  logic [7:0]           din_q;
  logic                 wr_q;
  logic                 div_tc;

  assign div_tc = (div_q == DW'(CLK_DIV - 1));

`ifdef SPI_LSB_FIRST_EN
  assign shift_d = {spi_miso, shift_q[7:1]};
`else
  assign shift_d = {shift_q[6:0], spi_miso};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      rem_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      din_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wr_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (rd_len != '0) begin
              rem_q   <= rd_len;
              busy_q  <= 1'b1;
              cs_n_q  <= 1'b0;
              div_q   <= '0;
              state_q <= SETUP;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (div_tc) begin
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= SHIFT;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        SHIFT: begin
          if (div_tc) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              shift_q <= shift_d;
            end else begin
              bit_q <= bit_q + 1'b1;
              if (bit_q == 3'd7) state_q <= PUSH;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        PUSH: begin
          // Stall here with SCLK low until the FIFO has room.
          if (!fifo_full) begin
            wr_q  <= 1'b1;
            din_q <= shift_q;
            rem_q <= rem_q - 1'b1;
            div_q <= '0;
            bit_q <= '0;
            if (rem_q == LEN_WIDTH'(1)) begin
              cs_n_q  <= 1'b1;
              state_q <= HOLD;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        HOLD: begin
          if (div_tc) begin
            div_q   <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign spi_sclk   = sclk_q;
  assign spi_cs_n   = cs_n_q;
  assign fifo_din   = din_q;
  assign fifo_wr_en = wr_q;

endmodule

// File: tb/tb_spi_rx_collector.sv
// Self-checking bench for spi_rx_collector with a mode-0 slave model.
// Bytes are generated randomly and predicted from the transmitted bit order.
module tb_spi_rx_collector;

  localparam int CLK_DIV = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rd_len = '0;
  logic       busy, done, spi_sclk, spi_cs_n;
  logic       spi_miso = 1'b0;
  logic [7:0] fifo_din;
  logic       fifo_wr_en;
  logic       fifo_full = 1'b0;

  spi_rx_collector #(.CLK_DIV(CLK_DIV), .LEN_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rd_len     (rd_len),
    .busy       (busy),
    .done       (done),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_miso   (spi_miso),
    .fifo_din   (fifo_din),
    .fifo_wr_en (fifo_wr_en),
    .fifo_full  (fifo_full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sclk_rise, cs_rise, cs_fall, done_cnt;
  int cs_rise_cyc, done_cyc, busy_err, stall_err;
  bit stall_mon = 1'b0;
  logic p_sclk = 1'b0;
  logic p_cs = 1'b1;
  bit         miso_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always @(posedge clk) cyc++;

  // Mode-0 slave: a new bit appears on CS fall and after every SCLK fall.
  always @(negedge spi_cs_n or negedge spi_sclk) begin
    if (!spi_cs_n) spi_miso = (miso_q.size() > 0) ? miso_q.pop_front() : 1'b0;
  end

  always @(negedge clk) begin
    if (fifo_wr_en) got_q.push_back(fifo_din);
    if (spi_sclk && !p_sclk) sclk_rise++;
    if (spi_cs_n && !p_cs) begin cs_rise++; cs_rise_cyc = cyc; end
    if (!spi_cs_n && p_cs) cs_fall++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (!spi_cs_n && !busy) busy_err++;
    if (stall_mon && (spi_sclk || spi_cs_n || fifo_wr_en)) stall_err++;
    p_sclk = spi_sclk;
    p_cs = spi_cs_n;
  end

  function automatic logic [7:0] model_byte(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
`ifdef SPI_LSB_FIRST_EN
      r[i] = v[7-i];
`else
      r[7-i] = v[7-i];
`endif
    end
    return r;
  endfunction

  task automatic load_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) miso_q.push_back(v[i]);
    exp_q.push_back(model_byte(v));
  endtask

  task automatic clear_mon();
    sclk_rise = 0; cs_rise = 0; cs_fall = 0; done_cnt = 0;
    busy_err = 0; stall_err = 0; cs_rise_cyc = 0; done_cyc = 0;
    got_q.delete();
  endtask

  task automatic pulse_start(input logic [7:0] len);
    @(negedge clk); #1;
    start = 1'b1; rd_len = len;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input bit rnd_full);
    int d0 = done_cnt;
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) begin ok = 1'b1; break; end
      if (rnd_full) fifo_full = 1'($urandom_range(0, 1));
    end
    fifo_full = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL done_timeout: no done within %0d cycles", maxc);
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_bytes(input string name);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL %s_count: got %0d writes, want %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s_byte%0d: got %02h, want %02h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, spi_sclk, spi_cs_n, fifo_din, fifo_wr_en} !== {4'b0001, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_vals: got %b/%b/%b/%b/%02h/%b, want 0/0/0/1/00/0",
               busy, done, spi_sclk, spi_cs_n, fifo_din, fifo_wr_en);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    miso_q.delete(); exp_q.delete(); clear_mon();
    load_byte(8'hA5);
    pulse_start(8'd1);
    wait_done(400, 1'b0);
    check_bytes("single");
    total++;
    if (sclk_rise !== 8) begin
      bad++; $display("FAIL single_sclk: got %0d rises, want 8", sclk_rise);
    end
    total++;
    if (done_cyc - cs_rise_cyc !== CLK_DIV) begin
      bad++;
      $display("FAIL single_cs_to_done: got %0d cycles, want %0d", done_cyc - cs_rise_cyc, CLK_DIV);
    end
    total++;
    if (busy_err !== 0 || done_cnt !== 1) begin
      bad++;
      $display("FAIL single_busy_done: got busy_err=%0d done=%0d, want 0/1", busy_err, done_cnt);
    end
  endtask

  task automatic test_multi();
    miso_q.delete(); exp_q.delete(); clear_mon();
    load_byte(8'h01); load_byte(8'h80); load_byte(8'hFF);
    pulse_start(8'd3);
    wait_done(800, 1'b0);
    check_bytes("multi");
    total++;
    if (sclk_rise !== 24) begin
      bad++; $display("FAIL multi_sclk: got %0d rises, want 24", sclk_rise);
    end
    total++;
    if (cs_fall !== 1 || cs_rise !== 1) begin
      bad++;
      $display("FAIL multi_cs: got falls=%0d rises=%0d, want 1/1", cs_fall, cs_rise);
    end
  endtask

  task automatic test_stall();
    bit seen = 1'b0;
    miso_q.delete(); exp_q.delete(); clear_mon();
    load_byte(8'($urandom)); load_byte(8'($urandom));
    fifo_full = 1'b1;
    pulse_start(8'd2);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (sclk_rise >= 8 && !spi_sclk) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL stall_reach: got no byte-1 end, want 8 rises");
    end
    stall_mon = 1'b1;
    repeat (20) @(negedge clk);
    #1 stall_mon = 1'b0;
    total++;
    if (stall_err !== 0 || got_q.size() !== 0) begin
      bad++;
      $display("FAIL stall_hold: got err=%0d writes=%0d, want 0/0", stall_err, got_q.size());
    end
    fifo_full = 1'b0;
    wait_done(600, 1'b0);
    check_bytes("stall");
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen = 1'b0;
    miso_q.delete(); exp_q.delete(); clear_mon();
    for (int i = 0; i < 3; i++) load_byte(8'($urandom));
    pulse_start(8'd3);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (sclk_rise >= 12) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL rstmid_reach: got %0d rises, want 12", sclk_rise);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({spi_cs_n, spi_sclk, busy, fifo_wr_en} !== 4'b1000) begin
      bad++;
      $display("FAIL rstmid_outs: got cs=%b sclk=%b busy=%b wr=%b, want 1/0/0/0",
               spi_cs_n, spi_sclk, busy, fifo_wr_en);
    end
    n = got_q.size();
    repeat (3) @(negedge clk);
    total++;
    if (n !== 1 || got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
      bad++;
      $display("FAIL rstmid_writes: got %0d/%0d writes, want 1/1 with first byte", n, got_q.size());
    end
    #1 rst = 1'b0;
    miso_q.delete(); exp_q.delete(); clear_mon();
    load_byte(8'($urandom));
    pulse_start(8'd1);
    wait_done(400, 1'b0);
    check_bytes("rstmid_after");
  endtask

  task automatic test_start_busy();
    miso_q.delete(); exp_q.delete(); clear_mon();
    load_byte(8'($urandom)); load_byte(8'($urandom));
    pulse_start(8'd2);
    repeat (10) @(negedge clk);
    pulse_start(8'd5);
    wait_done(800, 1'b0);
    check_bytes("busy_start");
    total++;
    if (sclk_rise !== 16 || done_cnt !== 1) begin
      bad++;
      $display("FAIL busy_start_sclk: got %0d rises %0d done, want 16/1", sclk_rise, done_cnt);
    end
    clear_mon();
    pulse_start(8'd0);
    repeat (4) @(negedge clk);
    total++;
    if (done_cnt !== 1 || cs_fall !== 0 || sclk_rise !== 0 || busy_err !== 0) begin
      bad++;
      $display("FAIL zero_len: got done=%0d csf=%0d sclk=%0d, want 1/0/0", done_cnt, cs_fall, sclk_rise);
    end
  endtask

  task automatic test_bit_order();
    logic [7:0] want;
`ifdef SPI_LSB_FIRST_EN
    want = 8'h01;
`else
    want = 8'h80;
`endif
    miso_q.delete(); exp_q.delete(); clear_mon();
    load_byte(8'h80);
    pulse_start(8'd1);
    wait_done(400, 1'b0);
    total++;
    if (got_q.size() !== 1 || got_q[0] !== want) begin
      bad++;
      $display("FAIL bit_order: got %0d writes first %02h, want 1 write %02h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx, want);
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      int len = $urandom_range(1, 4);
      miso_q.delete(); exp_q.delete(); clear_mon();
      for (int i = 0; i < len; i++) load_byte(8'($urandom));
      pulse_start(8'(len));
      wait_done(3000, 1'b1);
      check_bytes("random");
      total++;
      if (sclk_rise !== 8 * len || cs_fall !== 1 || busy_err !== 0) begin
        bad++;
        $display("FAIL random_bus: got sclk=%0d csf=%0d berr=%0d, want %0d/1/0",
                 sclk_rise, cs_fall, busy_err, 8 * len);
      end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single();
    test_multi();
    test_stall();
    test_reset_mid();
    test_start_busy();
    test_bit_order();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
